// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: instruction constants,
// immediate-extension selector and the decode-side instruction field layout.
package core_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_AW   = 4;

    // MOV r0, r0 -- used as the bubble instruction
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;
    localparam logic [REG_AW-1:0]  REG_PC    = 4'd15;

    typedef enum logic [1:0] {
        IMM_8   = 2'b00,
        IMM_12  = 2'b01,
        IMM_BR  = 2'b10,
        IMM_RSV = 2'b11
    } imm_src_e;

    // Data-processing / memory instruction field layout
    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] low;
    } instr_fields_t;

endpackage

// File: rtl/extend_unit.sv
// Immediate extension unit.
// Ports:
//   instr_i   - low 24 bits of the instruction
//   imm_src_i - immediate format selector
//   ext_imm_o - zero- or sign-extended immediate (combinational)
module extend_unit
    import core_pkg::*;
(
    input  logic [23:0]        instr_i,
    input  imm_src_e           imm_src_i,
    output logic [INSTR_W-1:0] ext_imm_o
);

    // Select the extension format; the reserved encoding yields zero
    always_comb begin
        ext_imm_o = '0;
        unique case (imm_src_i)
            IMM_8:   ext_imm_o = {24'b0, instr_i[7:0]};
            IMM_12:  ext_imm_o = {20'b0, instr_i[11:0]};
            IMM_BR:  ext_imm_o = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
            IMM_RSV: ext_imm_o = '0;
            default: ext_imm_o = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// Fetch-to-decode pipeline register with stall/flush control, combinational
// decode-side field extraction and a saturating stall-cycle debug counter.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   instr_f, pcplus4_f      - instruction and PC+4 from fetch
//   valid_f                 - fetch output is a real instruction
//   stall_d, flush_d        - hold / bubble the decode stage (flush wins)
//   reg_src, imm_src        - decoder controls for RA selection and Extend
//   instr_d, valid_d        - registered instruction and its valid flag
//   pcplus8_d               - registered PC+8
//   cond_d..rd_d            - instruction field slices of instr_d
//   ra1_d, ra2_d            - register-file read addresses
//   ext_imm_d               - extended immediate
//   stall_cnt               - saturating count of stalled valid cycles
module fetch_decode_reg
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  instr_f,
    input  logic [DATA_WIDTH-1:0]  pcplus4_f,
    input  logic                   valid_f,
    input  logic                   stall_d,
    input  logic                   flush_d,
    input  logic [1:0]             reg_src,
    input  logic [1:0]             imm_src,
    output logic [DATA_WIDTH-1:0]  instr_d,
    output logic                   valid_d,
    output logic [DATA_WIDTH-1:0]  pcplus8_d,
    output logic [3:0]             cond_d,
    output logic [1:0]             op_d,
    output logic [5:0]             funct_d,
    output logic [3:0]             rd_d,
    output logic [3:0]             ra1_d,
    output logic [3:0]             ra2_d,
    output logic [DATA_WIDTH-1:0]  ext_imm_d,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [DATA_WIDTH-1:0]  instr_reg_q, instr_reg_d;
    logic                   valid_reg_q, valid_reg_d;
    logic [DATA_WIDTH-1:0]  pc8_reg_q,   pc8_reg_d;
    logic [STALL_CNT_W-1:0] cnt_reg_q,   cnt_reg_d;

    instr_fields_t          fields;
    logic [INSTR_W-1:0]     ext_imm;

    // Next-state: flush > stall > load; the counter only moves on a held valid slot
    always_comb begin
        instr_reg_d = instr_reg_q;
        valid_reg_d = valid_reg_q;
        pc8_reg_d   = pc8_reg_q;
        cnt_reg_d   = cnt_reg_q;
        if (flush_d) begin
            instr_reg_d = DATA_WIDTH'(NOP_INSTR);
            valid_reg_d = 1'b0;
            pc8_reg_d   = '0;
        end else if (stall_d) begin
            if (valid_reg_q && (cnt_reg_q != '1)) begin
                cnt_reg_d = cnt_reg_q + STALL_CNT_W'(1);
            end
        end else begin
            instr_reg_d = instr_f;
            valid_reg_d = valid_f;
            pc8_reg_d   = pcplus4_f + DATA_WIDTH'(4);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg_q <= DATA_WIDTH'(NOP_INSTR);
            valid_reg_q <= 1'b0;
            pc8_reg_q   <= '0;
            cnt_reg_q   <= '0;
        end else begin
            instr_reg_q <= instr_reg_d;
            valid_reg_q <= valid_reg_d;
            pc8_reg_q   <= pc8_reg_d;
            cnt_reg_q   <= cnt_reg_d;
        end
    end

    assign instr_d   = instr_reg_q;
    assign valid_d   = valid_reg_q;
    assign pcplus8_d = pc8_reg_q;
    assign stall_cnt = cnt_reg_q;

    // Decode-side fields come from the registered instruction only
    assign fields  = instr_fields_t'(instr_reg_q[INSTR_W-1:0]);
    assign cond_d  = fields.cond;
    assign op_d    = fields.op;
    assign funct_d = fields.funct;
    assign rd_d    = fields.rd;
    assign ra1_d   = reg_src[0] ? REG_PC : fields.rn;
    assign ra2_d   = reg_src[1] ? fields.rd : fields.low[3:0];

    extend_unit u_extend (
        .instr_i   (instr_reg_q[23:0]),
        .imm_src_i (imm_src_e'(imm_src)),
        .ext_imm_o (ext_imm)
    );

    assign ext_imm_d = DATA_WIDTH'(ext_imm);

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Self-checking bench for fetch_decode_reg: directed vector table,
// long-stall saturation sequence and randomized run against a reference model.
module tb_fetch_decode_reg;

    logic        clk;
    logic        reset;
    logic [31:0] instr_f;
    logic [31:0] pcplus4_f;
    logic        valid_f;
    logic        stall_d;
    logic        flush_d;
    logic [1:0]  reg_src;
    logic [1:0]  imm_src;
    logic [31:0] instr_d;
    logic        valid_d;
    logic [31:0] pcplus8_d;
    logic [3:0]  cond_d;
    logic [1:0]  op_d;
    logic [5:0]  funct_d;
    logic [3:0]  rd_d;
    logic [3:0]  ra1_d;
    logic [3:0]  ra2_d;
    logic [31:0] ext_imm_d;
    logic [7:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_pc8;
    int          m_cnt;

    fetch_decode_reg #(.DATA_WIDTH(32), .STALL_CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_f   (instr_f),
        .pcplus4_f (pcplus4_f),
        .valid_f   (valid_f),
        .stall_d   (stall_d),
        .flush_d   (flush_d),
        .reg_src   (reg_src),
        .imm_src   (imm_src),
        .instr_d   (instr_d),
        .valid_d   (valid_d),
        .pcplus8_d (pcplus8_d),
        .cond_d    (cond_d),
        .op_d      (op_d),
        .funct_d   (funct_d),
        .rd_d      (rd_d),
        .ra1_d     (ra1_d),
        .ra2_d     (ra2_d),
        .ext_imm_d (ext_imm_d),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fl, st, vf;
        logic [31:0] ins, pc4;
        logic [1:0]  rs, is;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_pc8;
        logic [7:0]  e_cnt;
        logic [3:0]  e_ra1, e_ra2;
        logic [31:0] e_ext;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate extension written as arithmetic on the offset value
    function automatic logic [31:0] m_ext(input logic [31:0] ins, input logic [1:0] is);
        int off;
        case (is)
            2'd0: return ins % 256;
            2'd1: return ins % 4096;
            2'd2: begin
                off = int'(ins % 32'd16777216);
                if (off >= 8388608) off = off - 16777216;
                return 32'(off * 4);
            end
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model across the edge
    task automatic apply(input logic rst, input logic fl, input logic st, input logic vf,
                         input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [1:0] rs, input logic [1:0] is);
        reset = rst; flush_d = fl; stall_d = st; valid_f = vf;
        instr_f = ins; pcplus4_f = pc4; reg_src = rs; imm_src = is;
        @(posedge clk);
        if (rst) begin
            m_instr = 32'hE1A00000; m_valid = 1'b0; m_pc8 = 32'd0; m_cnt = 0;
        end else if (fl) begin
            m_instr = 32'hE1A00000; m_valid = 1'b0; m_pc8 = 32'd0;
        end else if (st) begin
            if (m_valid && m_cnt < 255) m_cnt = m_cnt + 1;
        end else begin
            m_instr = ins; m_valid = vf; m_pc8 = 32'(pc4 + 32'd4);
        end
        #1;
    endtask

    task automatic check_model();
        logic [31:0] mi;
        mi = m_instr;
        chk("m_instr", instr_d, m_instr);
        chk("m_valid", 32'(valid_d), 32'(m_valid));
        chk("m_pc8", pcplus8_d, m_pc8);
        chk("m_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("m_cond", 32'(cond_d), mi / 32'h10000000);
        chk("m_op", 32'(op_d), (mi / 32'h04000000) % 4);
        chk("m_funct", 32'(funct_d), (mi / 32'h00100000) % 64);
        chk("m_rd", 32'(rd_d), (mi / 32'h1000) % 16);
        chk("m_ra1", 32'(ra1_d), reg_src[0] ? 32'd15 : (mi / 32'h10000) % 16);
        chk("m_ra2", 32'(ra2_d), reg_src[1] ? (mi / 32'h1000) % 16 : mi % 16);
        chk("m_ext", ext_imm_d, m_ext(mi, imm_src));
    endtask

    initial begin
        //            rst  fl   st   vf   instr          pc4            rs     is      e_instr        ev   e_pc8         cnt    ra1    ra2    ext
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,         32'h0,         2'b00, 2'b00,  32'hE1A00000, 1'b0,32'h0,       8'd0,  4'd0,  4'd0,  32'h0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,32'h12345678,  32'h100,       2'b00, 2'b00,  32'hE1A00000, 1'b0,32'h0,       8'd0,  4'd0,  4'd0,  32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,32'hE2810005,  32'h10,        2'b00, 2'b00,  32'hE2810005, 1'b1,32'h14,      8'd0,  4'd1,  4'd5,  32'h5};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,32'hEAFFFFFE,  32'h20,        2'b00, 2'b10,  32'hEAFFFFFE, 1'b1,32'h24,      8'd0,  4'hF,  4'hE,  32'hFFFFFFF8};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,32'hE5801004,  32'h30,        2'b10, 2'b01,  32'hE5801004, 1'b1,32'h34,      8'd0,  4'd0,  4'd1,  32'h4};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,32'h11111111,  32'h40,        2'b10, 2'b01,  32'hE5801004, 1'b1,32'h34,      8'd1,  4'd0,  4'd1,  32'h4};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,32'h22222222,  32'h44,        2'b10, 2'b01,  32'hE5801004, 1'b1,32'h34,      8'd2,  4'd0,  4'd1,  32'h4};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,32'h33333333,  32'h48,        2'b10, 2'b01,  32'hE5801004, 1'b1,32'h34,      8'd3,  4'd0,  4'd1,  32'h4};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,32'h44444444,  32'h4C,        2'b00, 2'b00,  32'hE1A00000, 1'b0,32'h0,       8'd3,  4'd0,  4'd0,  32'h0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,32'hE3A0100F,  32'hFFFFFFFC,  2'b01, 2'b00,  32'hE3A0100F, 1'b0,32'h0,       8'd3,  4'hF,  4'hF,  32'hF};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1,32'h55555555,  32'h60,        2'b01, 2'b00,  32'hE3A0100F, 1'b0,32'h0,       8'd3,  4'hF,  4'hF,  32'hF};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b1,32'hE0812003,  32'h40,        2'b11, 2'b11,  32'hE0812003, 1'b1,32'h44,      8'd3,  4'hF,  4'd2,  32'h0};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b1,32'h66666666,  32'h70,        2'b00, 2'b00,  32'hE1A00000, 1'b0,32'h0,       8'd0,  4'd0,  4'd0,  32'h0};

        reset = 1'b1; flush_d = 1'b0; stall_d = 1'b0; valid_f = 1'b0;
        instr_f = '0; pcplus4_f = '0; reg_src = '0; imm_src = '0;
        m_instr = 32'hE1A00000; m_valid = 1'b0; m_pc8 = '0; m_cnt = 0;

        // Directed vectors with hand-derived expectations
        for (int i = 0; i < 13; i++) begin
            vec_t v;
            v = vecs[i];
            apply(v.rst, v.fl, v.st, v.vf, v.ins, v.pc4, v.rs, v.is);
            chk($sformatf("v%0d_instr", i), instr_d, v.e_instr);
            chk($sformatf("v%0d_valid", i), 32'(valid_d), 32'(v.e_valid));
            chk($sformatf("v%0d_pc8", i), pcplus8_d, v.e_pc8);
            chk($sformatf("v%0d_cnt", i), 32'(stall_cnt), 32'(v.e_cnt));
            chk($sformatf("v%0d_cond", i), 32'(cond_d), 32'(v.e_instr[31:28]));
            chk($sformatf("v%0d_ra1", i), 32'(ra1_d), 32'(v.e_ra1));
            chk($sformatf("v%0d_ra2", i), 32'(ra2_d), 32'(v.e_ra2));
            chk($sformatf("v%0d_ext", i), ext_imm_d, v.e_ext);
        end

        // Long stall on a valid instruction: counter saturates and holds
        apply(1'b0, 1'b0, 1'b0, 1'b1, 32'hE2810005, 32'h80, 2'b00, 2'b00);
        for (int i = 0; i < 300; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 2'b00, 2'b00);
            check_model();
        end
        chk("sat_cnt", 32'(stall_cnt), 32'hFF);
        chk("sat_instr", instr_d, 32'hE2810005);
        // Flush leaves the saturated counter intact, then a further stall keeps it pinned
        apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("flush_keeps_cnt", 32'(stall_cnt), 32'hFF);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 32'hE1A00000, 32'h90, 2'b00, 2'b00);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("sat_hold", 32'(stall_cnt), 32'hFF);

        // Randomized run against the model
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        check_model();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc4;
            pc4 = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
            apply($urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 8,
                  $urandom, pc4,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
